// File: rtl/pe_conv_stream_pkg.sv
// Shared defaults and arithmetic helpers for the streaming convolution PE.
// sat_psum works on a 64-bit carrier so one function can serve every PSUM_W.
package pe_conv_stream_pkg;

    localparam int K_DEF      = 3;
    localparam int PIX_W_DEF  = 8;
    localparam int WGT_W_DEF  = 4;
    localparam int PSUM_W_DEF = 16;
    localparam bit SAT_DEF    = 1'b1;
    localparam int EB_W       = 5;
    localparam int CALC_W     = 64;

    // One sign bit of headroom on top of the worst-case K*K product sum
    function automatic int dot_width(input int k, input int pix_w, input int wgt_w);
        return pix_w + wgt_w + $clog2(k * k) + 1;
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_psum(
        input logic signed [CALC_W-1:0] v,
        input int                       w,
        input bit                       sat
    );
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (sat) begin
            if (v > hi) return hi;
            if (v < lo) return lo;
            return v;
        end
        return (v <<< (CALC_W - w)) >>> (CALC_W - w);
    endfunction

endpackage

// File: rtl/pe_conv_stream_if.sv
// Column input stream and partial-sum output stream of one PE, both valid/ready.
// The slave view belongs to the PE; the master view belongs to whoever feeds and drains it.
interface pe_conv_stream_if
    import pe_conv_stream_pkg::*;
#(
    parameter int K      = K_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int PSUM_W = PSUM_W_DEF
);
    logic                in_valid;
    logic                in_ready;
    logic [K*PIX_W-1:0]  image_in;
    logic [PSUM_W-1:0]   psum_in;
    logic                out_valid;
    logic                out_ready;
    logic [PSUM_W-1:0]   psum_out;

    modport master (
        output in_valid, image_in, psum_in, out_ready,
        input  in_ready, out_valid, psum_out
    );

    modport slave (
        input  in_valid, image_in, psum_in, out_ready,
        output in_ready, out_valid, psum_out
    );
endinterface

// File: rtl/pe_conv_stream_win_buf.sv
// KxK sliding pixel window: the newest column is taken straight from col_in so the
// window seen by the multipliers already includes the column being accepted.
module pe_conv_stream_win_buf
    import pe_conv_stream_pkg::*;
#(
    parameter int K     = K_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   shift,
    input  logic [K*PIX_W-1:0]     col_in,
    output logic [K*K*PIX_W-1:0]   window,
    output logic                   win_full
);
    localparam int CNT_W = $clog2(K + 1);

    // Only the K-1 older columns need storage; column 0 is always col_in
    logic [K*PIX_W-1:0] hist [K-1];
    logic [CNT_W-1:0]   fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill <= '0;
            for (int j = 0; j < K - 1; j++) hist[j] <= '0;
        end else if (flush) begin
            fill <= '0;
        end else if (shift) begin
            hist[0] <= col_in;
            for (int j = 1; j < K - 1; j++) hist[j] <= hist[j-1];
            if (fill != CNT_W'(K)) fill <= fill + CNT_W'(1);
        end
    end

    // Pixel (row r, column c) sits at window index r*K + c, c = 0 being the newest
    always_comb begin
        window = '0;
        for (int r = 0; r < K; r++) begin
            window[(r*K)*PIX_W +: PIX_W] = col_in[r*PIX_W +: PIX_W];
            for (int c = 1; c < K; c++)
                window[(r*K+c)*PIX_W +: PIX_W] = hist[c-1][r*PIX_W +: PIX_W];
        end
    end

    // True when the column being shifted in completes the window
    assign win_full = (fill >= CNT_W'(K - 1));

endmodule

// File: rtl/pe_conv_stream.sv
// Streaming convolution PE: KxK window times signed weights, shifted by exp_bias,
// added to the chained partial sum, two register stages to a valid/ready output.
module pe_conv_stream
    import pe_conv_stream_pkg::*;
#(
    parameter int K      = K_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int WGT_W  = WGT_W_DEF,
    parameter int PSUM_W = PSUM_W_DEF,
    parameter bit SAT    = SAT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [EB_W-1:0]        exp_bias,
    input  logic                   wgt_load,
    input  logic [K*K*WGT_W-1:0]   wgt_in,
    pe_conv_stream_if.slave        bus
);
    localparam int N      = K * K;
    localparam int PROD_W = PIX_W + WGT_W + 1;
    localparam int DOT_W  = dot_width(K, PIX_W, WGT_W);
    localparam int FULL_W = ((DOT_W > PSUM_W) ? DOT_W : PSUM_W) + 2;

    logic [N*WGT_W-1:0]         wgt_q;
    logic [N*PIX_W-1:0]         window;
    logic                       win_full;
    logic                       stall;
    logic                       accept;
    logic                       prod_acc;

    logic signed [PROD_W-1:0]   prod_c  [N];
    logic signed [PROD_W-1:0]   prod_p1 [N];
    logic signed [PSUM_W-1:0]   psum_p1;
    logic [EB_W-1:0]            bias_p1;
    logic                       vld_p1;

    logic signed [DOT_W-1:0]    dot_sum;
    logic signed [DOT_W-1:0]    dot_shift;
    logic signed [FULL_W-1:0]   total;
    logic signed [PSUM_W-1:0]   psum_next;
    logic signed [PSUM_W-1:0]   psum_p2;
    logic                       vld_p2;

    // A held output freezes the whole pipe, so upstream is stalled with it
    assign stall        = vld_p2 && !bus.out_ready;
    assign bus.in_ready = !stall;
    assign accept       = bus.in_valid && !stall;
    assign prod_acc     = accept && win_full && !flush;

    pe_conv_stream_win_buf #(
        .K     (K),
        .PIX_W (PIX_W)
    ) u_win_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .shift    (accept),
        .col_in   (bus.image_in),
        .window   (window),
        .win_full (win_full)
    );

    // A load coinciding with an accept lands after that column's products register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           wgt_q <= '0;
        else if (wgt_load) wgt_q <= wgt_in;
    end

    always_comb begin
        for (int i = 0; i < N; i++)
            prod_c[i] = PROD_W'($signed({1'b0, window[i*PIX_W +: PIX_W]}))
                      * PROD_W'($signed(wgt_q[i*WGT_W +: WGT_W]));
    end

    // ---- stage 1 -> stage 2: reduce, shift, add chained psum, clamp or wrap ----
    always_comb begin
        dot_sum = '0;
        for (int i = 0; i < N; i++)
            dot_sum = dot_sum + DOT_W'(prod_p1[i]);
        dot_shift = dot_sum >>> bias_p1;
        total     = FULL_W'(dot_shift) + FULL_W'(psum_p1);
        psum_next = PSUM_W'(sat_psum(CALC_W'(total), PSUM_W, SAT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            bias_p1 <= '0;
            psum_p1 <= '0;
            psum_p2 <= '0;
            for (int i = 0; i < N; i++) prod_p1[i] <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (!stall) begin
            // ---- input -> stage 1 ----
            vld_p1 <= prod_acc;
            if (prod_acc) begin
                prod_p1 <= prod_c;
                psum_p1 <= $signed(bus.psum_in);
                bias_p1 <= exp_bias;
            end
            // ---- stage 2 -> output ----
            vld_p2 <= vld_p1;
            if (vld_p1) psum_p2 <= psum_next;
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.psum_out  = psum_p2;

endmodule

// File: tb/tb_pe_conv_stream.sv
// Bench for pe_conv_stream: a saturating and a wrapping instance share one stimulus
// stream and are scored against a transaction-level window/dot-product model.
module tb_pe_conv_stream;
    import pe_conv_stream_pkg::*;

    localparam int K      = 3;
    localparam int PIX_W  = 8;
    localparam int WGT_W  = 4;
    localparam int PSUM_W = 16;
    localparam int N      = K * K;

    typedef int col_t [K];
    typedef struct { int s; int w; } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 flush = 1'b0;
    logic [EB_W-1:0]      exp_bias = '0;
    logic                 wgt_load = 1'b0;
    logic [N*WGT_W-1:0]   wgt_in = '0;
    logic                 in_valid = 1'b0;
    logic [K*PIX_W-1:0]   image_in = '0;
    logic [PSUM_W-1:0]    psum_in = '0;
    logic                 out_ready = 1'b1;

    always #5 clk = ~clk;

    pe_conv_stream_if #(.K(K), .PIX_W(PIX_W), .PSUM_W(PSUM_W)) bus_s ();
    pe_conv_stream_if #(.K(K), .PIX_W(PIX_W), .PSUM_W(PSUM_W)) bus_w ();

    assign bus_s.in_valid  = in_valid;
    assign bus_s.image_in  = image_in;
    assign bus_s.psum_in   = psum_in;
    assign bus_s.out_ready = out_ready;
    assign bus_w.in_valid  = in_valid;
    assign bus_w.image_in  = image_in;
    assign bus_w.psum_in   = psum_in;
    assign bus_w.out_ready = out_ready;

    pe_conv_stream #(.K(K), .PIX_W(PIX_W), .WGT_W(WGT_W), .PSUM_W(PSUM_W), .SAT(1'b1)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .exp_bias(exp_bias),
        .wgt_load(wgt_load), .wgt_in(wgt_in), .bus(bus_s.slave)
    );

    pe_conv_stream #(.K(K), .PIX_W(PIX_W), .WGT_W(WGT_W), .PSUM_W(PSUM_W), .SAT(1'b0)) dut_w (
        .clk(clk), .rst(rst), .flush(flush), .exp_bias(exp_bias),
        .wgt_load(wgt_load), .wgt_in(wgt_in), .bus(bus_w.slave)
    );

    int    n_cmp = 0;
    int    n_err = 0;

    // Reference model state: recent columns (newest first), weights, expected outputs
    col_t  m_hist[$];
    int    m_wgt [N];
    exp_t  m_exp[$];

    logic  smp_in_ready, smp_ov_s, smp_ov_w;
    int    smp_ps_s, smp_ps_w;
    logic  prev_hold = 1'b0;
    int    prev_ps_s, prev_ps_w;

    function automatic int wrap_psum(input longint v);
        longint m;
        m = v & ((64'sd1 << PSUM_W) - 1);
        if (m >= (64'sd1 << (PSUM_W - 1))) m = m - (64'sd1 << PSUM_W);
        return int'(m);
    endfunction

    function automatic int clamp_psum(input longint v);
        longint hi;
        hi = (64'sd1 << (PSUM_W - 1)) - 1;
        if (v > hi) return int'(hi);
        if (v < -hi - 1) return int'(-hi - 1);
        return int'(v);
    endfunction

    function automatic exp_t model_result(input int eb, input int ps);
        longint dot;
        longint tot;
        exp_t   e;
        dot = 0;
        for (int c = 0; c < K; c++)
            for (int r = 0; r < K; r++)
                dot += longint'(m_hist[c][r]) * longint'(m_wgt[r*K + c]);
        tot = (dot >>> eb) + longint'(ps);
        e.s = clamp_psum(tot);
        e.w = wrap_psum(tot);
        return e;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_exp.delete();
        for (int i = 0; i < N; i++) m_wgt[i] = 0;
        prev_hold = 1'b0;
    endtask

    task automatic set_pix_all(input int v);
        for (int r = 0; r < K; r++) image_in[r*PIX_W +: PIX_W] = PIX_W'(v);
    endtask

    task automatic set_wgt_all(input int v);
        for (int i = 0; i < N; i++) wgt_in[i*WGT_W +: WGT_W] = WGT_W'(v);
    endtask

    task automatic rand_pix();
        for (int r = 0; r < K; r++) image_in[r*PIX_W +: PIX_W] = PIX_W'($urandom);
    endtask

    task automatic rand_wgt();
        for (int i = 0; i < N; i++) wgt_in[i*WGT_W +: WGT_W] = WGT_W'($urandom);
    endtask

    // One clock: sample at negedge, score the output handshake, update model at posedge
    task automatic step();
        logic acc, hs;
        col_t col;
        exp_t e;
        @(negedge clk);
        smp_in_ready = bus_s.in_ready;
        smp_ov_s     = bus_s.out_valid;
        smp_ov_w     = bus_w.out_valid;
        smp_ps_s     = int'($signed(bus_s.psum_out));
        smp_ps_w     = int'($signed(bus_w.psum_out));
        n_cmp++;
        if (smp_in_ready !== !(smp_ov_s && !out_ready)) begin
            n_err++;
            $display("FAIL in_ready_rule: in_ready=%b out_valid=%b out_ready=%b", smp_in_ready, smp_ov_s, out_ready);
        end
        n_cmp++;
        if (smp_ov_w !== smp_ov_s || bus_w.in_ready !== smp_in_ready) begin
            n_err++;
            $display("FAIL sat_wrap_lockstep: out_valid sat=%b wrap=%b", smp_ov_s, smp_ov_w);
        end
        if (prev_hold) begin
            n_cmp++;
            if (smp_ov_s !== 1'b1 || smp_ps_s != prev_ps_s || smp_ps_w != prev_ps_w) begin
                n_err++;
                $display("FAIL hold_stable: got v=%b %0d/%0d want v=1 %0d/%0d",
                         smp_ov_s, smp_ps_s, smp_ps_w, prev_ps_s, prev_ps_w);
            end
        end
        acc = in_valid && smp_in_ready;
        hs  = smp_ov_s && out_ready;
        if (hs) begin
            n_cmp++;
            if (m_exp.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got %0d/%0d want none", smp_ps_s, smp_ps_w);
            end else begin
                e = m_exp.pop_front();
                if (smp_ps_s != e.s || smp_ps_w != e.w) begin
                    n_err++;
                    $display("FAIL psum_out: got sat=%0d wrap=%0d want sat=%0d wrap=%0d",
                             smp_ps_s, smp_ps_w, e.s, e.w);
                end
            end
        end
        prev_hold = smp_ov_s && !out_ready && !flush;
        prev_ps_s = smp_ps_s;
        prev_ps_w = smp_ps_w;
        @(posedge clk);
        if (flush) begin
            m_hist.delete();
            m_exp.delete();
        end else if (acc) begin
            for (int r = 0; r < K; r++) col[r] = int'(image_in[r*PIX_W +: PIX_W]);
            if (m_hist.size() >= K - 1) begin
                m_hist.push_front(col);
                if (m_hist.size() > K) void'(m_hist.pop_back());
                m_exp.push_back(model_result(int'(exp_bias), int'($signed(psum_in))));
            end else begin
                m_hist.push_front(col);
            end
        end
        if (wgt_load)
            for (int i = 0; i < N; i++) m_wgt[i] = int'($signed(wgt_in[i*WGT_W +: WGT_W]));
        #1;
    endtask

    task automatic wait_output(output logic got, output int vs, output int vw);
        got = 1'b0; vs = 0; vw = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (smp_ov_s === 1'b1) begin
                got = 1'b1; vs = smp_ps_s; vw = smp_ps_w;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus_s.out_valid !== 1'b0 || bus_s.psum_out !== '0 || bus_s.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: out_valid=%b psum_out=%0d in_ready=%b want 0/0/1",
                     bus_s.out_valid, bus_s.psum_out, bus_s.in_ready);
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_fill();
        logic seen;
        exp_bias = '0; set_wgt_all(1); wgt_load = 1'b1; in_valid = 1'b0;
        step();
        wgt_load = 1'b0;
        in_valid = 1'b1; set_pix_all(1); psum_in = '0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen |= smp_ov_s;
        end
        in_valid = 1'b0;
        step();
        seen |= smp_ov_s;
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL fill_early: got out_valid=%b want 0", seen);
        end
        step();
        n_cmp++;
        if (smp_ov_s !== 1'b1 || smp_ps_s != 9) begin
            n_err++;
            $display("FAIL fill_latency: got v=%b psum=%0d want v=1 psum=9", smp_ov_s, smp_ps_s);
        end
    endtask

    task automatic prep(input int w, input int eb);
        set_wgt_all(w); wgt_load = 1'b1; flush = 1'b1; in_valid = 1'b0;
        exp_bias = EB_W'(eb);
        step();
        wgt_load = 1'b0; flush = 1'b0;
    endtask

    task automatic test_signed_shift();
        logic got; int vs, vw;
        prep(-8, 2);
        in_valid = 1'b1; set_pix_all(255); psum_in = PSUM_W'(100);
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0;
        wait_output(got, vs, vw);
        n_cmp++;
        if (!got || vs != -4490 || vw != -4490) begin
            n_err++;
            $display("FAIL signed_shift: got v=%b %0d/%0d want -4490", got, vs, vw);
        end
    endtask

    task automatic test_saturation();
        logic got; int vs, vw;
        prep(7, 0);
        in_valid = 1'b1; set_pix_all(255); psum_in = PSUM_W'(32000);
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0;
        wait_output(got, vs, vw);
        n_cmp++;
        if (!got || vs != 32767) begin
            n_err++;
            $display("FAIL sat_clamp: got v=%b %0d want 32767", got, vs);
        end
        n_cmp++;
        if (!got || vw != -17471) begin
            n_err++;
            $display("FAIL sat_wrap: got v=%b %0d want -17471", got, vw);
        end
    endtask

    task automatic test_backpressure();
        logic saw_block;
        rand_wgt(); wgt_load = 1'b1; flush = 1'b1; in_valid = 1'b0;
        step();
        wgt_load = 1'b0; flush = 1'b0;
        saw_block = 1'b0;
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1; rand_pix(); psum_in = PSUM_W'($urandom);
            exp_bias = EB_W'($urandom_range(0, 4));
            out_ready = !(i >= 10 && i < 14);
            step();
            if (i >= 10 && i < 14 && smp_in_ready === 1'b0) saw_block = 1'b1;
        end
        n_cmp++;
        if (!saw_block) begin
            n_err++;
            $display("FAIL bp_ready_drop: got in_ready held 1 want 0 while stalled");
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        n_cmp++;
        if (m_exp.size() != 0) begin
            n_err++;
            $display("FAIL bp_drain: got %0d outputs missing want 0", m_exp.size());
        end
    endtask

    task automatic test_flush_wgt();
        int nout;
        int vals[2];
        prep(1, 0);
        in_valid = 1'b1; set_pix_all(1); psum_in = '0;
        for (int i = 0; i < 3; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        nout = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (smp_ov_s === 1'b1) nout++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (smp_ov_s === 1'b1) nout++;
        end
        n_cmp++;
        if (nout != 0) begin
            n_err++;
            $display("FAIL flush_nout: got %0d outputs want 0", nout);
        end
        in_valid = 1'b1; set_wgt_all(2); wgt_load = 1'b1;
        step();
        wgt_load = 1'b0;
        step();
        in_valid = 1'b0;
        nout = 0; vals[0] = 0; vals[1] = 0;
        for (int i = 0; i < 8 && nout < 2; i++) begin
            step();
            if (smp_ov_s === 1'b1) begin
                vals[nout] = smp_ps_s;
                nout++;
            end
        end
        n_cmp++;
        if (nout != 2 || vals[0] != 9 || vals[1] != 18) begin
            n_err++;
            $display("FAIL wgt_load_timing: got n=%0d %0d,%0d want 2 9,18", nout, vals[0], vals[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic got; int vs, vw;
        prep(1, 0);
        in_valid = 1'b1; set_pix_all(2); psum_in = PSUM_W'(5);
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0; out_ready = 1'b0;
        wait_output(got, vs, vw);
        n_cmp++;
        if (!got || vs != 23) begin
            n_err++;
            $display("FAIL mid_pre: got v=%b %0d want v=1 23", got, vs);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus_s.out_valid !== 1'b0 || bus_s.psum_out !== '0 || bus_s.in_ready !== 1'b1 ||
            bus_w.out_valid !== 1'b0 || bus_w.psum_out !== '0 || bus_w.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: got v=%b psum=%0d rdy=%b want 0/0/1",
                     bus_s.out_valid, bus_s.psum_out, bus_s.in_ready);
        end
        model_reset();
        out_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            rand_pix();
            psum_in   = PSUM_W'($urandom);
            exp_bias  = EB_W'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 3);
            wgt_load  = ($urandom_range(0, 99) < 5);
            if (wgt_load) rand_wgt();
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; wgt_load = 1'b0;
        for (int i = 0; i < 6; i++) step();
        n_cmp++;
        if (m_exp.size() != 0) begin
            n_err++;
            $display("FAIL b2b_drain: got %0d outputs missing want 0", m_exp.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_signed_shift();
        test_saturation();
        test_backpressure();
        test_flush_wgt();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
